// File: rtl/cal_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cal_pkg : shared types, month constants and calendar helper functions |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package cal_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DIV400 = 2'd1,
        ST_DIV100 = 2'd2,
        ST_CHECK  = 2'd3
    } cal_state_t;

    localparam logic [3:0] c_month_feb = 4'd2;
    localparam logic [3:0] c_month_dec = 4'd12;

    function automatic logic [4:0] dim_days(input logic [3:0] month, input logic leap);
        case (month)
            c_month_feb:               dim_days = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   dim_days = 5'd30;
            default:                   dim_days = 5'd31;
        endcase
    endfunction

    // Day of week of 1 January of a year, 0 = Sunday (Gauss's rule).
    function automatic logic [2:0] jan1_dow(input int year);
        int y1;
        y1 = year - 1;
        jan1_dow = 3'((1 + 5 * (y1 % 4) + 4 * (y1 % 100) + 6 * (y1 % 400)) % 7);
    endfunction

    localparam logic [2:0] c_dow_jan1_2000 = jan1_dow(2000);

endpackage
`default_nettype wire

// File: rtl/cal_dim_lut.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cal_dim_lut : month + leap flag -> number of days in that month       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cal_dim_lut
    import cal_pkg::*;
(
    input  logic [3:0] month,
    input  logic       leap,
    output logic [4:0] days
);

    assign days = dim_days(month, leap);

endmodule
`default_nettype wire

// File: rtl/calendar_date_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | calendar_date_counter : Gregorian day/month/year counter with residue |
// | based leap detection and validated multi-cycle load.                  |
// | Optional day-of-week tracking with macro CAL_DOW_EN.                  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module calendar_date_counter
    import cal_pkg::*;
#(
    parameter int YEAR_W   = 12,
    parameter int YEAR_MIN = 2000,
    parameter int YEAR_MAX = 3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              day_tick,
    input  logic              load,
    input  logic [4:0]        load_day,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
`ifdef CAL_DOW_EN
    input  logic [2:0]        load_dow,
    output logic [2:0]        dow,
`endif
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              is_leap_year,
    output logic [4:0]        days_in_month,
    output logic              busy,
    output logic              load_err,
    output logic              year_wrap
);

    localparam logic [YEAR_W-1:0] c_year_min = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] c_year_max = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] c_400      = YEAR_W'(400);
    localparam logic [YEAR_W-1:0] c_100      = YEAR_W'(100);
    localparam logic [8:0]        c_r400_rst = 9'(YEAR_MIN % 400);
    localparam logic [6:0]        c_r100_rst = 7'(YEAR_MIN % 100);
    localparam logic [1:0]        c_r4_rst   = 2'(YEAR_MIN % 4);

    cal_state_t        r_state, w_state_nxt;

    logic [4:0]        r_day;
    logic [3:0]        r_month;
    logic [YEAR_W-1:0] r_year;
    logic [8:0]        r_r400;
    logic [6:0]        r_r100;
    logic [1:0]        r_r4;
    logic              r_pend;
    logic              r_load_err;
    logic              r_year_wrap;

    logic [4:0]        r_wk_day;
    logic [3:0]        r_wk_month;
    logic [YEAR_W-1:0] r_wk_year;
    logic [YEAR_W-1:0] r_wk_rem;
    logic [8:0]        r_wk_r400;
    logic [6:0]        r_wk_r100;
    logic [1:0]        r_wk_r4;

`ifdef CAL_DOW_EN
    localparam logic [2:0] c_dow_rst = jan1_dow(YEAR_MIN);
    logic [2:0]        r_dow;
    logic [2:0]        r_wk_dow;
`endif

    logic              w_leap, w_wk_leap, w_wk_valid;
    logic [4:0]        w_dim, w_wk_dim;

    assign w_leap    = (r_r400 == 9'd0)    || ((r_r4 == 2'd0)    && (r_r100 != 7'd0));
    assign w_wk_leap = (r_wk_r400 == 9'd0) || ((r_wk_r4 == 2'd0) && (r_wk_r100 != 7'd0));

    cal_dim_lut u_dim_live  (.month(r_month),    .leap(w_leap),    .days(w_dim));
    cal_dim_lut u_dim_check (.month(r_wk_month), .leap(w_wk_leap), .days(w_wk_dim));

    assign w_wk_valid = (r_wk_year >= c_year_min) && (r_wk_year <= c_year_max)
                     && (r_wk_month >= 4'd1) && (r_wk_month <= c_month_dec)
                     && (r_wk_day != 5'd0) && (r_wk_day <= w_wk_dim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (load)             w_state_nxt = ST_DIV400;
            ST_DIV400: if (r_wk_rem < c_400) w_state_nxt = ST_DIV100;
            ST_DIV100: if (r_wk_rem < c_100) w_state_nxt = ST_CHECK;
            ST_CHECK:                        w_state_nxt = ST_RUN;
            default:                         w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_day       <= 5'd1;
            r_month     <= 4'd1;
            r_year      <= c_year_min;
            r_r400      <= c_r400_rst;
            r_r100      <= c_r100_rst;
            r_r4        <= c_r4_rst;
            r_pend      <= 1'b0;
            r_load_err  <= 1'b0;
            r_year_wrap <= 1'b0;
            r_wk_day    <= 5'd0;
            r_wk_month  <= 4'd0;
            r_wk_year   <= '0;
            r_wk_rem    <= '0;
            r_wk_r400   <= 9'd0;
            r_wk_r100   <= 7'd0;
            r_wk_r4     <= 2'd0;
`ifdef CAL_DOW_EN
            r_dow       <= c_dow_rst;
            r_wk_dow    <= 3'd0;
`endif
        end else begin
            r_load_err  <= 1'b0;
            r_year_wrap <= 1'b0;
            if (r_state != ST_RUN && day_tick) r_pend <= 1'b1;
            case (r_state)
                ST_RUN: begin
                    if (load) begin
                        // A tick coinciding with the load is deferred, not lost.
                        r_pend     <= r_pend | day_tick;
                        r_wk_day   <= load_day;
                        r_wk_month <= load_month;
                        r_wk_year  <= load_year;
                        r_wk_rem   <= load_year;
`ifdef CAL_DOW_EN
                        r_wk_dow   <= load_dow;
`endif
                    end else if (day_tick || r_pend) begin
                        r_pend <= 1'b0;
`ifdef CAL_DOW_EN
                        r_dow  <= (r_dow == 3'd6) ? 3'd0 : r_dow + 3'd1;
`endif
                        if (r_day < w_dim) begin
                            r_day <= r_day + 5'd1;
                        end else begin
                            r_day <= 5'd1;
                            if (r_month < c_month_dec) begin
                                r_month <= r_month + 4'd1;
                            end else begin
                                r_month <= 4'd1;
                                if (r_year == c_year_max) begin
                                    r_year      <= c_year_min;
                                    r_r400      <= c_r400_rst;
                                    r_r100      <= c_r100_rst;
                                    r_r4        <= c_r4_rst;
                                    r_year_wrap <= 1'b1;
                                end else begin
                                    r_year <= r_year + YEAR_W'(1);
                                    r_r400 <= (r_r400 == 9'd399) ? 9'd0 : r_r400 + 9'd1;
                                    r_r100 <= (r_r100 == 7'd99)  ? 7'd0 : r_r100 + 7'd1;
                                    r_r4   <= r_r4 + 2'd1;
                                end
                            end
                        end
                    end
                end
                ST_DIV400: begin
                    if (r_wk_rem >= c_400) r_wk_rem  <= r_wk_rem - c_400;
                    else                   r_wk_r400 <= r_wk_rem[8:0];
                end
                ST_DIV100: begin
                    // Remainder here is year mod 100, whose low two bits equal year mod 4.
                    if (r_wk_rem >= c_100) begin
                        r_wk_rem <= r_wk_rem - c_100;
                    end else begin
                        r_wk_r100 <= r_wk_rem[6:0];
                        r_wk_r4   <= r_wk_rem[1:0];
                    end
                end
                ST_CHECK: begin
                    if (w_wk_valid) begin
                        r_day   <= r_wk_day;
                        r_month <= r_wk_month;
                        r_year  <= r_wk_year;
                        r_r400  <= r_wk_r400;
                        r_r100  <= r_wk_r100;
                        r_r4    <= r_wk_r4;
`ifdef CAL_DOW_EN
                        r_dow   <= r_wk_dow;
`endif
                    end else begin
                        r_load_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign day           = r_day;
    assign month         = r_month;
    assign year          = r_year;
    assign is_leap_year  = w_leap;
    assign days_in_month = w_dim;
    assign busy          = (r_state != ST_RUN);
    assign load_err      = r_load_err;
    assign year_wrap     = r_year_wrap;
`ifdef CAL_DOW_EN
    assign dow           = r_dow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_calendar_date_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_calendar_date_counter : self-checking bench with calendar model    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_calendar_date_counter;

    localparam int YEAR_W   = 12;
    localparam int YEAR_MIN = 2000;
    localparam int YEAR_MAX = 3000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              day_tick;
    logic              load;
    logic [4:0]        load_day;
    logic [3:0]        load_month;
    logic [YEAR_W-1:0] load_year;
    logic [4:0]        day;
    logic [3:0]        month;
    logic [YEAR_W-1:0] year;
    logic              is_leap_year;
    logic [4:0]        days_in_month;
    logic              busy;
    logic              load_err;
    logic              year_wrap;
`ifdef CAL_DOW_EN
    logic [2:0]        load_dow;
    logic [2:0]        dow;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int m_day, m_month, m_year;

    always #5 clk = ~clk;

    calendar_date_counter #(
        .YEAR_W(YEAR_W), .YEAR_MIN(YEAR_MIN), .YEAR_MAX(YEAR_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .load(load),
        .load_day(load_day), .load_month(load_month), .load_year(load_year),
`ifdef CAL_DOW_EN
        .load_dow(load_dow), .dow(dow),
`endif
        .day(day), .month(month), .year(year), .is_leap_year(is_leap_year),
        .days_in_month(days_in_month), .busy(busy), .load_err(load_err),
        .year_wrap(year_wrap)
    );

    // ---------------- reference model ----------------
    function automatic bit ref_leap(int y);
        return (y % 400 == 0) || ((y % 4 == 0) && (y % 100 != 0));
    endfunction

    function automatic int ref_dim(int m, int y);
        case (m)
            2:           return ref_leap(y) ? 29 : 28;
            4, 6, 9, 11: return 30;
            default:     return 31;
        endcase
    endfunction

    function automatic int ref_busy(int y);
        return y / 400 + (y % 400) / 100 + 3;
    endfunction

    task automatic ref_advance(output bit wrap);
        wrap = 1'b0;
        if (m_day < ref_dim(m_month, m_year)) m_day++;
        else begin
            m_day = 1;
            if (m_month < 12) m_month++;
            else begin
                m_month = 1;
                if (m_year == YEAR_MAX) begin m_year = YEAR_MIN; wrap = 1'b1; end
                else m_year++;
            end
        end
    endtask

    task automatic ref_load(input int d, input int m, input int y, output bit valid);
        valid = (y >= YEAR_MIN) && (y <= YEAR_MAX) && (m >= 1) && (m <= 12)
             && (d >= 1) && (d <= ref_dim(m, y));
        if (valid) begin m_day = d; m_month = m; m_year = y; end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        day_tick = 1'b1;
        step();
        day_tick = 1'b0;
    endtask

    // Issues a load and follows it until busy drops; returns busy length and load_err.
    task automatic run_load(input int d, input int m, input int y, input bit tick_same,
                            input bit tick_busy, input bit extra_load,
                            output int bcyc, output bit err);
        load_day = 5'(d); load_month = 4'(m); load_year = YEAR_W'(y);
        load = 1'b1; day_tick = tick_same;
        step();
        load = 1'b0; day_tick = 1'b0;
        bcyc = 0;
        while (busy === 1'b1 && bcyc < 64) begin
            bcyc++;
            day_tick = tick_busy && (bcyc == 2);
            load     = extra_load && (bcyc == 3);
            if (load) begin load_day = 5'd1; load_month = 4'd1; load_year = YEAR_W'(2500); end
            step();
        end
        day_tick = 1'b0; load = 1'b0;
        err = load_err;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        m_day = 1; m_month = 1; m_year = YEAR_MIN;
        n_checks++;
        if (day !== 5'd1 || month !== 4'd1 || year !== YEAR_W'(YEAR_MIN)) begin
            n_fail++;
            $display("FAIL reset_date: got %0d/%0d/%0d expected 1/1/%0d", day, month, year, YEAR_MIN);
        end
        n_checks++;
        if (is_leap_year !== 1'b1 || days_in_month !== 5'd31) begin
            n_fail++;
            $display("FAIL reset_leap_dim: got leap=%0b dim=%0d expected leap=1 dim=31", is_leap_year, days_in_month);
        end
        n_checks++;
        if (busy !== 1'b0 || load_err !== 1'b0 || year_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got busy=%0b err=%0b wrap=%0b expected 0 0 0", busy, load_err, year_wrap);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_century_2100();
        int bc; bit err, v, w;
        ref_load(28, 2, 2100, v);
        run_load(28, 2, 2100, 1'b0, 1'b0, 1'b0, bc, err);
        n_checks++;
        if (bc !== 9 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_2100: got busy_cycles=%0d err=%0b expected 9 0", bc, err);
        end
        n_checks++;
        if (is_leap_year !== 1'b0 || days_in_month !== 5'd28) begin
            n_fail++;
            $display("FAIL leap_2100: got leap=%0b dim=%0d expected 0 28", is_leap_year, days_in_month);
        end
        pulse_tick(); ref_advance(w);
        n_checks++;
        if (day !== 5'(m_day) || month !== 4'(m_month) || year !== YEAR_W'(m_year)) begin
            n_fail++;
            $display("FAIL tick_2100: got %0d/%0d/%0d expected %0d/%0d/%0d", day, month, year, m_day, m_month, m_year);
        end
    endtask

    task automatic test_leap_2400();
        int bc; bit err, v, w;
        ref_load(28, 2, 2400, v);
        run_load(28, 2, 2400, 1'b0, 1'b0, 1'b0, bc, err);
        n_checks++;
        if (bc !== 9 || err !== 1'b0 || is_leap_year !== 1'b1) begin
            n_fail++;
            $display("FAIL load_2400: got busy_cycles=%0d err=%0b leap=%0b expected 9 0 1", bc, err, is_leap_year);
        end
        for (int i = 0; i < 2; i++) begin
            pulse_tick(); ref_advance(w);
            n_checks++;
            if (day !== 5'(m_day) || month !== 4'(m_month) || year !== YEAR_W'(m_year)) begin
                n_fail++;
                $display("FAIL tick_2400_%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", i, day, month, year, m_day, m_month, m_year);
            end
            step();
        end
    endtask

    task automatic test_load_err();
        int tbl_d[4] = '{29, 1, 31, 15};
        int tbl_m[4] = '{2, 1, 4, 13};
        int tbl_y[4] = '{2023, 3001, 2024, 2024};
        int bc; bit err, v;
        for (int i = 0; i < 4; i++) begin
            ref_load(tbl_d[i], tbl_m[i], tbl_y[i], v);
            run_load(tbl_d[i], tbl_m[i], tbl_y[i], 1'b0, 1'b0, 1'b0, bc, err);
            n_checks++;
            if (err !== 1'b1 || day !== 5'(m_day) || month !== 4'(m_month) || year !== YEAR_W'(m_year)) begin
                n_fail++;
                $display("FAIL load_err_%0d: got err=%0b date %0d/%0d/%0d expected err=1 date %0d/%0d/%0d",
                         i, err, day, month, year, m_day, m_month, m_year);
            end
            step();
            n_checks++;
            if (load_err !== 1'b0) begin
                n_fail++;
                $display("FAIL load_err_pulse_%0d: got %0b expected 0", i, load_err);
            end
        end
    endtask

    task automatic test_wrap();
        int bc; bit err, v, w;
        ref_load(31, 12, YEAR_MAX, v);
        run_load(31, 12, YEAR_MAX, 1'b0, 1'b0, 1'b0, bc, err);
        pulse_tick(); ref_advance(w);
        n_checks++;
        if (day !== 5'(m_day) || month !== 4'(m_month) || year !== YEAR_W'(m_year) || year_wrap !== w) begin
            n_fail++;
            $display("FAIL wrap: got %0d/%0d/%0d wrap=%0b expected %0d/%0d/%0d wrap=%0b",
                     day, month, year, year_wrap, m_day, m_month, m_year, w);
        end
        n_checks++;
        if (is_leap_year !== 1'(ref_leap(m_year))) begin
            n_fail++;
            $display("FAIL wrap_leap: got %0b expected %0b", is_leap_year, ref_leap(m_year));
        end
        step();
        n_checks++;
        if (year_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_pulse: got %0b expected 0", year_wrap);
        end
    endtask

    task automatic test_pending();
        int bc; bit err, v, w;
        ref_load(15, 6, 2024, v);
        run_load(15, 6, 2024, 1'b0, 1'b1, 1'b1, bc, err);
        n_checks++;
        if (bc !== ref_busy(2024) || day !== 5'(m_day) || month !== 4'(m_month) || year !== YEAR_W'(m_year)) begin
            n_fail++;
            $display("FAIL pend_commit: got busy_cycles=%0d %0d/%0d/%0d expected %0d %0d/%0d/%0d",
                     bc, day, month, year, ref_busy(2024), m_day, m_month, m_year);
        end
        step(); ref_advance(w);
        n_checks++;
        if (day !== 5'(m_day) || month !== 4'(m_month) || year !== YEAR_W'(m_year)) begin
            n_fail++;
            $display("FAIL pend_apply: got %0d/%0d/%0d expected %0d/%0d/%0d", day, month, year, m_day, m_month, m_year);
        end
    endtask

    task automatic test_load_tick_same();
        int bc; bit err, v, w;
        ref_load(31, 1, 2024, v);
        run_load(31, 1, 2024, 1'b1, 1'b0, 1'b0, bc, err);
        step(); ref_advance(w);
        n_checks++;
        if (day !== 5'(m_day) || month !== 4'(m_month) || year !== YEAR_W'(m_year)) begin
            n_fail++;
            $display("FAIL load_tick_same: got %0d/%0d/%0d expected %0d/%0d/%0d", day, month, year, m_day, m_month, m_year);
        end
    endtask

    task automatic test_random();
        int bc, d, m, y, n; bit err, v, w;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                d = $urandom_range(0, 31); m = $urandom_range(0, 13); y = $urandom_range(1990, 3010);
            end else begin
                d = $urandom_range(20, 31); m = $urandom_range(1, 12);
                y = ($urandom_range(0, 3) == 0) ? YEAR_MAX : $urandom_range(YEAR_MIN, YEAR_MAX);
            end
            ref_load(d, m, y, v);
            run_load(d, m, y, 1'b0, 1'b0, 1'b0, bc, err);
            n_checks++;
            if (bc !== ref_busy(y) || err !== !v || day !== 5'(m_day) || month !== 4'(m_month) || year !== YEAR_W'(m_year)) begin
                n_fail++;
                $display("FAIL rnd_load_%0d (%0d/%0d/%0d): got bc=%0d err=%0b %0d/%0d/%0d expected bc=%0d err=%0b %0d/%0d/%0d",
                         it, d, m, y, bc, err, day, month, year, ref_busy(y), !v, m_day, m_month, m_year);
            end
            n = $urandom_range(1, 40);
            for (int k = 0; k < n; k++) begin
                pulse_tick(); ref_advance(w);
                n_checks++;
                if (day !== 5'(m_day) || month !== 4'(m_month) || year !== YEAR_W'(m_year) || year_wrap !== w
                    || is_leap_year !== 1'(ref_leap(m_year)) || days_in_month !== 5'(ref_dim(m_month, m_year))) begin
                    n_fail++;
                    $display("FAIL rnd_tick_%0d_%0d: got %0d/%0d/%0d wrap=%0b leap=%0b dim=%0d expected %0d/%0d/%0d wrap=%0b leap=%0b dim=%0d",
                             it, k, day, month, year, year_wrap, is_leap_year, days_in_month,
                             m_day, m_month, m_year, w, ref_leap(m_year), ref_dim(m_month, m_year));
                end
                if ($urandom_range(0, 1) == 1) step();
            end
        end
    endtask

    task automatic test_reset_midload();
        load_day = 5'd1; load_month = 4'd1; load_year = YEAR_W'(2999);
        load = 1'b1;
        step();
        load = 1'b0;
        day_tick = 1'b1;
        step();
        day_tick = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        m_day = 1; m_month = 1; m_year = YEAR_MIN;
        n_checks++;
        if (busy !== 1'b0 || day !== 5'd1 || month !== 4'd1 || year !== YEAR_W'(YEAR_MIN)) begin
            n_fail++;
            $display("FAIL reset_midload: got busy=%0b %0d/%0d/%0d expected busy=0 1/1/%0d", busy, day, month, year, YEAR_MIN);
        end
        step();
        rst_n = 1'b1;
        repeat (4) step();
        n_checks++;
        if (busy !== 1'b0 || day !== 5'd1 || month !== 4'd1 || year !== YEAR_W'(YEAR_MIN)) begin
            n_fail++;
            $display("FAIL reset_pend_clear: got busy=%0b %0d/%0d/%0d expected busy=0 1/1/%0d", busy, day, month, year, YEAR_MIN);
        end
    endtask

    initial begin
        rst_n = 1'b0; day_tick = 1'b0; load = 1'b0;
        load_day = 5'd0; load_month = 4'd0; load_year = '0;
`ifdef CAL_DOW_EN
        load_dow = 3'd0;
`endif
        test_reset();
        test_century_2100();
        test_leap_2400();
        test_load_err();
        test_wrap();
        test_pending();
        test_load_tick_same();
        test_random();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
